// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Bit-serial adder/subtractor. A single full-adder cell processes one bit
//   per clock, LSB first. A carry flip-flop links the bits.
//   Subtraction is done as A + ~B + ~Cin, so Cout=1 means "no borrow".
//
// Parameters
//   WIDTH        operand/result width in bits (2..64)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   Start        request. Sampled only in IDLE or DONE.
//   Sub          0: A+B+Cin, 1: A-B-Cin. Captured with Start.
//   A, B         operands. Captured with Start.
//   Cin          carry-in / borrow-in. Captured with Start.
//   Busy         high while bits are being processed
//   Done         one-cycle pulse when Sum/Cout/Ovf are newly valid
//   Sum          result. Held until the next completion.
//   Cout         carry out (add) or not-borrow (sub)
//   Ovf          two's-complement overflow of the result
//   o_dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: Start is a request without a ready. It is accepted on any edge
// where the FSM is in IDLE or DONE. Done is a one-cycle valid strobe with no
// back-pressure. Busy and Done are decoded from the state register, so they
// are never high together.
// ---------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_carry_nxt;
  logic             w_last_bit;
  logic             w_accept;

  // Full-adder cell on the current LSBs.
  assign w_s         = r_op_a[0] ^ r_op_b[0] ^ r_carry;
  assign w_carry_nxt = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) |
                       (r_op_b[0] & r_carry);
  assign w_last_bit  = (r_cnt == CW'(WIDTH - 1));
  assign w_accept    = Start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_RUN;
      S_RUN:   if (w_last_bit) w_next_state = S_DONE;
      S_DONE:  w_next_state = w_accept ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        // Subtraction becomes addition of the complemented operand and the
        // complemented borrow-in.
        r_op_a  <= A;
        r_op_b  <= Sub ? ~B : B;
        r_carry <= Sub ? ~Cin : Cin;
        r_cnt   <= '0;
        r_res   <= '0;
      end else if (r_state == S_RUN) begin
        r_op_a  <= r_op_a >> 1;
        r_op_b  <= r_op_b >> 1;
        r_res   <= {w_s, r_res[WIDTH-1:1]};
        r_carry <= w_carry_nxt;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last_bit) begin
          // On the MSB cycle r_carry is the carry into the MSB and
          // w_carry_nxt is the carry out of it. Their XOR is the signed
          // overflow.
          r_sum  <= {w_s, r_res[WIDTH-1:1]};
          r_cout <= w_carry_nxt;
          r_ovf  <= r_carry ^ w_carry_nxt;
        end
      end
    end
  end

  assign Busy        = (r_state == S_RUN);
  assign Done        = (r_state == S_DONE);
  assign Sum         = r_sum;
  assign Cout        = r_cout;
  assign Ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//   Bench for serial_addsub at WIDTH 2, 8 and 33.
//   Directed vectors run on the 8-bit instance. Random regression runs on all
//   three instances. An arithmetic reference model predicts, for every cycle,
//   Busy, Done and the held Sum/Cout/Ovf of each instance.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  longint cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial cyc = 0;

  // ---------------- DUT signals (index 0: W2, 1: W8, 2: W33) ----------------
  logic        start_s[3];
  logic        sub_s[3];
  logic        cin_s[3];
  logic [63:0] a_s[3];
  logic [63:0] b_s[3];
  logic        busy_s[3];
  logic        done_s[3];
  logic        cout_s[3];
  logic        ovf_s[3];
  logic [1:0]  dbg_s[3];
  logic [1:0]  sum_w2;
  logic [7:0]  sum_w8;
  logic [32:0] sum_w33;

  serial_addsub #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .Start(start_s[0]), .Sub(sub_s[0]),
    .A(a_s[0][1:0]), .B(b_s[0][1:0]), .Cin(cin_s[0]),
    .Busy(busy_s[0]), .Done(done_s[0]), .Sum(sum_w2), .Cout(cout_s[0]),
    .Ovf(ovf_s[0]), .o_dbg_state(dbg_s[0])
  );

  serial_addsub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .Start(start_s[1]), .Sub(sub_s[1]),
    .A(a_s[1][7:0]), .B(b_s[1][7:0]), .Cin(cin_s[1]),
    .Busy(busy_s[1]), .Done(done_s[1]), .Sum(sum_w8), .Cout(cout_s[1]),
    .Ovf(ovf_s[1]), .o_dbg_state(dbg_s[1])
  );

  serial_addsub #(.WIDTH(33)) u_w33 (
    .clk(clk), .rst_n(rst_n), .Start(start_s[2]), .Sub(sub_s[2]),
    .A(a_s[2][32:0]), .B(b_s[2][32:0]), .Cin(cin_s[2]),
    .Busy(busy_s[2]), .Done(done_s[2]), .Sum(sum_w33), .Cout(cout_s[2]),
    .Ovf(ovf_s[2]), .o_dbg_state(dbg_s[2])
  );

  function automatic int wid(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 8 : 33);
  endfunction

  function automatic logic [63:0] get_sum(input int k);
    case (k)
      0:       return {62'd0, sum_w2};
      1:       return {56'd0, sum_w8};
      default: return {31'd0, sum_w33};
    endcase
  endfunction

  // ---------------- checking ----------------
  int checks;
  int errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the exact integer result, then wrap, carry and signed
  // range tests. The widths used here are at most 33, so longint is exact.
  function automatic void model(input int w, input logic sub, input logic [63:0] a,
                                input logic [63:0] b, input logic cin,
                                output logic [63:0] s, output logic co, output logic ov);
    longint m, ua, ub, sa, sb, r, sr, lim;
    m   = (longint'(1) <<< w);
    lim = (longint'(1) <<< (w - 1));
    ua  = longint'(a & 64'(m - 1));
    ub  = longint'(b & 64'(m - 1));
    sa  = (ua >= lim) ? ua - m : ua;
    sb  = (ub >= lim) ? ub - m : ub;
    if (sub) begin
      r  = ua - ub - longint'(cin);
      sr = sa - sb - longint'(cin);
      co = (r >= 0);
    end else begin
      r  = ua + ub + longint'(cin);
      sr = sa + sb + longint'(cin);
      co = (r >= m);
    end
    s  = 64'(r) & 64'(m - 1);
    ov = (sr < -lim) || (sr > lim - 1);
  endfunction

  typedef struct {
    int          k;
    longint      st;   // first cycle Busy must be high
    longint      due;  // cycle Done must be high
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] held_sum[3];
  logic        held_cout[3];
  logic        held_ovf[3];
  longint      last_due[3];

  task automatic clear_model();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      held_sum[k]  = '0;
      held_cout[k] = 1'b0;
      held_ovf[k]  = 1'b0;
      last_due[k]  = cyc;
    end
  endtask

  // Compare process: on every falling edge, check each instance against the
  // model's prediction for that cycle.
  always @(negedge clk) begin
    int   idx;
    logic eb;
    logic ed;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && exp_q[i].k == k) idx = i;
        eb = (idx >= 0) && (cyc >= exp_q[idx].st) && (cyc < exp_q[idx].due);
        ed = (idx >= 0) && (cyc == exp_q[idx].due);
        chk($sformatf("w%0d busy", wid(k)), 64'(busy_s[k]), 64'(eb));
        chk($sformatf("w%0d done", wid(k)), 64'(done_s[k]), 64'(ed));
        if (ed) begin
          held_sum[k]  = exp_q[idx].sum;
          held_cout[k] = exp_q[idx].cout;
          held_ovf[k]  = exp_q[idx].ovf;
          exp_q.delete(idx);
        end
        chk($sformatf("w%0d sum", wid(k)),  get_sum(k),        held_sum[k]);
        chk($sformatf("w%0d cout", wid(k)), 64'(cout_s[k]),    64'(held_cout[k]));
        chk($sformatf("w%0d ovf", wid(k)),  64'(ovf_s[k]),     64'(held_ovf[k]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drives operands and Start for instance k so that the next rising edge
  // captures them, and records the predicted result.
  task automatic issue(input int k, input logic sub, input logic [63:0] a,
                       input logic [63:0] b, input logic cin);
    exp_t e;
    sub_s[k]   = sub;
    a_s[k]     = a;
    b_s[k]     = b;
    cin_s[k]   = cin;
    start_s[k] = 1'b1;
    e.k   = k;
    e.st  = cyc + 1;
    e.due = cyc + 1 + wid(k);
    model(wid(k), sub, a, b, cin, e.sum, e.cout, e.ovf);
    exp_q.push_back(e);
    last_due[k] = e.due;
  endtask

  task automatic wait_done(input int k);
    while (cyc < last_due[k]) step(1);
  endtask

  // ---------------- directed vectors ----------------
  logic        d_sub[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0]  d_a[6]    = '{8'h5A, 8'hFF, 8'h7F, 8'h00, 8'h80, 8'h10};
  logic [7:0]  d_b[6]    = '{8'h33, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
  logic        d_cin[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0]  d_sum[6]  = '{8'h8D, 8'h00, 8'h80, 8'hFF, 8'h7F, 8'h0E};
  logic        d_cout[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        d_ovf[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [63:0] ms;
    logic        mc;
    logic        mo;
    checks = 0;
    errors = 0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      sub_s[k]   = 1'b0;
      cin_s[k]   = 1'b0;
      a_s[k]     = '0;
      b_s[k]     = '0;
    end
    rst_n = 1'b0;
    step(3);
    clear_model();
    rst_n = 1'b1;
    step(2);

    // Directed vectors on WIDTH=8, with literal expectations on both the
    // model and the DUT outputs in the Done cycle.
    for (int i = 0; i < 6; i++) begin
      model(8, d_sub[i], 64'(d_a[i]), 64'(d_b[i]), d_cin[i], ms, mc, mo);
      chk($sformatf("pin model sum v%0d", i),  ms,      64'(d_sum[i]));
      chk($sformatf("pin model cout v%0d", i), 64'(mc), 64'(d_cout[i]));
      chk($sformatf("pin model ovf v%0d", i),  64'(mo), 64'(d_ovf[i]));
      issue(1, d_sub[i], 64'(d_a[i]), 64'(d_b[i]), d_cin[i]);
      step(1);
      start_s[1] = 1'b0;
      wait_done(1);
      chk($sformatf("direct sum v%0d", i),  get_sum(1),      64'(d_sum[i]));
      chk($sformatf("direct cout v%0d", i), 64'(cout_s[1]),  64'(d_cout[i]));
      chk($sformatf("direct ovf v%0d", i),  64'(ovf_s[1]),   64'(d_ovf[i]));
      chk($sformatf("direct done v%0d", i), 64'(done_s[1]),  64'd1);
      step(1 + i % 2);
    end

    // Start pulsed with new operands mid-RUN must be ignored.
    issue(1, 1'b0, 64'h21, 64'h42, 1'b0);
    step(1);
    start_s[1] = 1'b0;
    step(3);
    start_s[1] = 1'b1;
    a_s[1]     = 64'hF0;
    b_s[1]     = 64'h0F;
    step(1);
    start_s[1] = 1'b0;
    wait_done(1);
    chk("ignored start sum", get_sum(1), 64'h63);
    step(2);

    // Start held high: back-to-back operations, one every 9 cycles.
    issue(1, 1'b0, 64'h12, 64'h34, 1'b0);
    step(1);
    wait_done(1);
    issue(1, 1'b1, 64'hF0, 64'h0F, 1'b1);
    step(1);
    chk("b2b sum held", get_sum(1), 64'h46);
    wait_done(1);
    issue(1, 1'b0, 64'h80, 64'h80, 1'b0);
    step(1);
    wait_done(1);
    issue(1, 1'b1, 64'h01, 64'h02, 1'b0);
    step(1);
    start_s[1] = 1'b0;
    wait_done(1);
    chk("b2b last sum", get_sum(1), 64'hFF);
    step(2);

    // Reset during bit 4 of an add: no Done, all outputs cleared.
    issue(1, 1'b0, 64'h5A, 64'h33, 1'b0);
    step(1);
    start_s[1] = 1'b0;
    step(3);
    rst_n = 1'b0;
    step(1);
    clear_model();
    rst_n = 1'b1;
    chk("reset sum",  get_sum(1),     64'd0);
    chk("reset busy", 64'(busy_s[1]), 64'd0);
    chk("reset done", 64'(done_s[1]), 64'd0);
    step(1);

    // Next operation after the reset uses normal latency.
    issue(1, 1'b0, 64'h7F, 64'h01, 1'b0);
    step(1);
    start_s[1] = 1'b0;
    wait_done(1);
    chk("post reset sum", get_sum(1), 64'h80);
    step(2);

    // Random regression on all three widths, mixing idle gaps and
    // back-to-back starts.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 25; n++) begin
        issue(k, 1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)},
              {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
        step(1);
        start_s[k] = 1'b0;
        wait_done(k);
        if ($urandom_range(0, 2) != 0) step($urandom_range(1, 3));
      end
      step(2);
    end

    step(3);
    chk("queue drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
